// File: rtl/led_fsm_multi.sv
// led_fsm_multi: N_CH independent push-button LED controllers.
// Each channel synchronises and debounces its button. Each debounced press
// steps the channel through OFF -> ON -> BLINK -> OFF. All blinking channels
// share one prescaler, so they blink in phase.
// Optional build macro: LED_FSM_AUTO_OFF_EN adds a per-channel idle timeout
// that returns ON/BLINK channels to OFF after TIMEOUT cycles without a press.

module led_fsm_multi_ch #(
    parameter int DEB_CYCLES = 16,
    parameter int TIMEOUT    = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_raw,
    input  logic       force_off,
    input  logic       blink_phase_d,
    output logic       led,
    output logic [1:0] state
);
    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_ON    = 2'b01,
        ST_BLINK = 2'b10,
        ST_BAD   = 2'b11
    } state_e;

    localparam int            DW       = $clog2(DEB_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d, deb_prev_q;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    state_e        state_q, state_d;
    logic          led_q, led_d;
    logic          press;

    // Debounce: accept a new level only after DEB_CYCLES stable cycles
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                deb_d     = sync2_q;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + DW'(1);
            end
        end
    end

    // Only the debounced rising edge counts as a press
    assign press = deb_q & ~deb_prev_q;

`ifdef LED_FSM_AUTO_OFF_EN
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          active;
    logic          tmo_hit;

    assign active  = (state_q == ST_ON) || (state_q == ST_BLINK);
    assign tmo_hit = active && (tmo_cnt_q == TMO_LAST);

    // Idle counter: runs only while lit and restarts on any press
    always_comb begin
        tmo_cnt_d = '0;
        if (active && !press && !force_off && !tmo_hit)
            tmo_cnt_d = tmo_cnt_q + TW'(1);
    end

    // Idle counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tmo_cnt_q <= '0;
        else        tmo_cnt_q <= tmo_cnt_d;
    end
`else
    // TIMEOUT only matters in the auto-off build
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
`endif

    // Next state and LED decode of the next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_OFF:   if (press) state_d = ST_ON;
            ST_ON:    if (press) state_d = ST_BLINK;
            ST_BLINK: if (press) state_d = ST_OFF;
            default:  state_d = ST_OFF;
        endcase
`ifdef LED_FSM_AUTO_OFF_EN
        // A press on the timeout edge wins over the timeout
        if (tmo_hit && !press) state_d = ST_OFF;
`endif
        if (force_off) state_d = ST_OFF;

        led_d = 1'b0;
        case (state_d)
            ST_ON:    led_d = 1'b1;
            ST_BLINK: led_d = blink_phase_d;
            default:  led_d = 1'b0;
        endcase
    end

    // Input path, FSM and LED registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
            state_q    <= ST_OFF;
            led_q      <= 1'b0;
        end else begin
            sync1_q    <= in_raw;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            deb_cnt_q  <= deb_cnt_d;
            state_q    <= state_d;
            led_q      <= led_d;
        end
    end

    assign led   = led_q;
    assign state = state_q;
endmodule

module led_fsm_multi #(
    parameter int N_CH       = 4,
    parameter int DEB_CYCLES = 16,
    parameter int BLINK_HALF = 25000000,
    parameter int TIMEOUT    = 100000000
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [N_CH-1:0]   IN,
    input  logic              Force_Off,
    output logic [N_CH-1:0]   Led,
    output logic [2*N_CH-1:0] Estado_Salida
);
    localparam int            PW       = $clog2(BLINK_HALF + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(BLINK_HALF - 1);

    logic [PW-1:0] pre_cnt_q, pre_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    // Free-running prescaler; the phase flips on each wrap
    always_comb begin
        pre_cnt_d     = pre_cnt_q + PW'(1);
        blink_phase_d = blink_phase_q;
        if (pre_cnt_q == PRE_LAST) begin
            pre_cnt_d     = '0;
            blink_phase_d = ~blink_phase_q;
        end
    end

    // Shared blink timebase registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pre_cnt_q     <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // Channels see the next phase so a registered LED tracks blink_phase_q
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        led_fsm_multi_ch #(
            .DEB_CYCLES (DEB_CYCLES),
            .TIMEOUT    (TIMEOUT)
        ) u_ch (
            .clk           (Clk),
            .rst_n         (Reset),
            .in_raw        (IN[c]),
            .force_off     (Force_Off),
            .blink_phase_d (blink_phase_d),
            .led           (Led[c]),
            .state         (Estado_Salida[2*c +: 2])
        );
    end
endmodule

// File: tb/tb_led_fsm_multi.sv
// Directed bench for led_fsm_multi with DEB_CYCLES=4, BLINK_HALF=4, TIMEOUT=8.
module tb_led_fsm_multi;
    localparam int N   = 4;
    localparam int DEB = 4;
    localparam int BH  = 4;
    localparam int TMO = 8;

    logic           Clk = 1'b0;
    logic           Reset = 1'b0;
    logic [N-1:0]   IN = '0;
    logic           Force_Off = 1'b0;
    logic [N-1:0]   Led;
    logic [2*N-1:0] Estado_Salida;

    int checks = 0;
    int errors = 0;
    int n_edges = 0;

    led_fsm_multi #(
        .N_CH       (N),
        .DEB_CYCLES (DEB),
        .BLINK_HALF (BH),
        .TIMEOUT    (TMO)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .IN            (IN),
        .Force_Off     (Force_Off),
        .Led           (Led),
        .Estado_Salida (Estado_Salida)
    );

    always #5 Clk = ~Clk;

    // Reference timebase: edges since reset release give prescaler and phase
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) n_edges <= 0;
        else        n_edges <= n_edges + 1;
    end

    function automatic logic exp_phase();
        return ((n_edges / BH) % 2) != 0;
    endfunction

    task automatic cyc(input int k);
        repeat (k) @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [N-1:0] m);
        IN = IN | m;
        cyc(10);
        IN = IN & ~m;
        cyc(10);
    endtask

    initial begin
        int bad;
        int toggles;
        int k;
        logic prev;

        // Reset state and idle hold
        cyc(3);
        chk("rst_led", 32'(Led), 0);
        chk("rst_state", 32'(Estado_Salida), 0);
        Reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            if (Led !== '0 || Estado_Salida !== '0) bad++;
        end
        chk("idle_100", bad, 0);

`ifdef LED_FSM_AUTO_OFF_EN
        // ON times out 8 cycles after entry (entry at E0+6, off at E0+14)
        IN[1] = 1'b1;
        cyc(7);
        chk("to_on", 32'(Estado_Salida[3:2]), 32'h1);
        cyc(3);
        IN[1] = 1'b0;
        cyc(4);
        chk("to_hold", 32'(Estado_Salida[3:2]), 32'h1);
        chk("to_hold_led", 32'(Led[1]), 1);
        cyc(1);
        chk("to_off", 32'(Estado_Salida[3:2]), 32'h0);
        chk("to_off_led", 32'(Led[1]), 0);
        cyc(10);

        // Second press lands exactly on the timeout edge E0+14
        IN[1] = 1'b1;
        cyc(4);
        IN[1] = 1'b0;
        cyc(4);
        IN[1] = 1'b1;
        cyc(3);
        chk("tc_on", 32'(Estado_Salida[3:2]), 32'h1);
        cyc(3);
        chk("tc_still_on", 32'(Estado_Salida[3:2]), 32'h1);
        cyc(1);
        chk("tc_blink", 32'(Estado_Salida[3:2]), 32'h2);
        cyc(7);
        chk("tc_blink_hold", 32'(Estado_Salida[3:2]), 32'h2);
        cyc(1);
        chk("tc_blink_timeout", 32'(Estado_Salida[3:2]), 32'h0);
        chk("tc_blink_timeout_led", 32'(Led[1]), 0);
        IN[1] = 1'b0;
        cyc(10);
`else
        // Latency: IN[0] set before E0, state and Led change at E0+6
        IN[0] = 1'b1;
        cyc(6);
        chk("lat_pre_state", 32'(Estado_Salida[1:0]), 32'h0);
        chk("lat_pre_led", 32'(Led[0]), 0);
        cyc(1);
        chk("lat_state", 32'(Estado_Salida[1:0]), 32'h1);
        chk("lat_led", 32'(Led[0]), 1);
        cyc(3);
        IN[0] = 1'b0;
        cyc(8);
        chk("release_no_event", 32'(Estado_Salida[1:0]), 32'h1);

        // 3-cycle glitch is filtered
        IN[0] = 1'b1;
        cyc(3);
        IN[0] = 1'b0;
        cyc(10);
        chk("glitch_state", 32'(Estado_Salida[1:0]), 32'h1);
        chk("glitch_led", 32'(Led[0]), 1);

        // Channel 2 full cycle and blink timing
        press(4'b0100);
        chk("ch2_on", 32'(Estado_Salida[5:4]), 32'h1);
        chk("ch2_on_led", 32'(Led[2]), 1);
        press(4'b0100);
        chk("ch2_blink", 32'(Estado_Salida[5:4]), 32'h2);
        bad = 0;
        toggles = 0;
        prev = Led[2];
        for (int i = 0; i < 16; i++) begin
            cyc(1);
            if (Led[2] !== exp_phase()) bad++;
            if (Led[2] !== prev) toggles++;
            prev = Led[2];
        end
        chk("blink_phase", bad, 0);
        chk("blink_toggles", toggles, 4);
        press(4'b0100);
        chk("ch2_off", 32'(Estado_Salida[5:4]), 32'h0);
        chk("ch2_off_led", 32'(Led[2]), 0);
        chk("ch0_untouched", 32'(Estado_Salida[1:0]), 32'h1);

        // Simultaneous presses on 0 and 3; Force_Off on channel 1's edge
        IN = 4'b1001;
        cyc(2);
        IN[1] = 1'b1;
        cyc(5);
        chk("sim_ch0", 32'(Estado_Salida[1:0]), 32'h2);
        chk("sim_ch3", 32'(Estado_Salida[7:6]), 32'h1);
        cyc(1);
        chk("sim_ch1_pending", 32'(Estado_Salida[3:2]), 32'h0);
        Force_Off = 1'b1;
        cyc(1);
        chk("force_state", 32'(Estado_Salida), 0);
        chk("force_led", 32'(Led), 0);
        Force_Off = 1'b0;
        cyc(10);
        chk("force_no_retrigger", 32'(Estado_Salida), 0);
        IN = '0;
        cyc(10);
        chk("force_release", 32'(Estado_Salida), 0);

        // Asynchronous reset between edges while a channel blinks lit
        press(4'b0100);
        press(4'b0100);
        chk("pre_rst_blink", 32'(Estado_Salida[5:4]), 32'h2);
        k = 0;
        do begin
            @(posedge Clk);
            #1;
            k++;
        end while (!exp_phase() && k < 8);
        chk("pre_rst_led", 32'(Led[2]), 1);
        #2;
        Reset = 1'b0;
        #1;
        chk("async_rst_led", 32'(Led), 0);
        chk("async_rst_state", 32'(Estado_Salida), 0);
        @(negedge Clk);
        cyc(2);
        Reset = 1'b1;
        cyc(5);
        chk("post_rst_state", 32'(Estado_Salida), 0);
        chk("post_rst_led", 32'(Led), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_fsm_multi.md
Name: led_fsm_multi

Overview:
- Parametrised multi-channel successor to the single-channel LED on/off Moore FSM.
- Each of N_CH channels synchronises and debounces its push input. Each rising press steps that channel's Moore FSM through OFF -> ON -> BLINK -> OFF.
- The LED output for each channel is registered. Packed per-channel state is exported for testbench checking.
- The block sits between raw board buttons and LED pins.

Parameters:
- N_CH, 4, number of independent channels (>=1).
- DEB_CYCLES, 16, consecutive stable cycles required to accept a new input level (>=1).
- BLINK_HALF, 25000000, clock cycles per blink half-period (>=2).
- TIMEOUT, 100000000, idle cycles before auto-off; used only with LED_FSM_AUTO_OFF_EN (>=1).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-low reset. Assertion is asynchronous; release is synchronous to Clk.
- IN  input  N_CH  raw, asynchronous per-channel push inputs (1 = pressed).
- Force_Off  input  1  synchronous; sends every channel to OFF.
- Led  output  N_CH  registered LED drive (1 = lit).
- Estado_Salida  output  2*N_CH  packed state. Channel c occupies bits [2c+1:2c].

Behaviour:
- One clock domain; Reset is asynchronous and active-low.
- Reset values (Reset=0): all channels OFF, Led=0, Estado_Salida=0, synchronisers and debounced levels 0, debounce counters 0, blink prescaler 0, blink_phase 0, timeout counters 0.
- State encoding: OFF=2'b00, ON=2'b01, BLINK=2'b10. Code 2'b11 is illegal; on the next clock it recovers to OFF.
- Input path, per channel:
  - 2-flop synchroniser.
  - Debouncer: a counter increments while the synchronised value differs from the debounced level. It clears to 0 whenever they are equal.
  - When the counter would reach DEB_CYCLES, the debounced level takes the new value and the counter clears.
  - A glitch shorter than DEB_CYCLES cycles produces no change.
- Press event: one-cycle pulse on a debounced 0->1 transition. A 1->0 transition generates no event.
- FSM transitions on a press:
  - OFF -> ON
  - ON -> BLINK
  - BLINK -> OFF
  - With no press, the state holds.
- Latency:
  - IN held high and set up before edge E0 gives a debounced level of 1 at edge E0+DEB_CYCLES+1.
  - State and Led update at edge E0+DEB_CYCLES+2.
  - Led is registered from next-state decode, so it changes on the same edge as the state.
- Led decode:
  - OFF gives 0.
  - ON gives 1.
  - BLINK gives the shared blink_phase.
- Blink timing:
  - One shared prescaler counts 0..BLINK_HALF-1, then wraps.
  - blink_phase toggles on the wrap edge.
  - Channels in BLINK are therefore phase-aligned.
  - The prescaler free-runs and is not restarted on entry to BLINK.
- Force_Off=1 at an edge sets every channel to OFF and Led=0 on that edge.
  - Force_Off overrides a simultaneous press.
  - The debouncers keep running, so a held button does not re-trigger after Force_Off drops (no new 0->1 edge).
- Channels are fully independent. Simultaneous presses on several channels each advance their own channel.
- Reset asserted mid-debounce or mid-blink returns everything to its reset values immediately, without waiting for a clock.
- Width rules:
  - Counter widths are $clog2(param+1).
  - No counter may overflow. Each saturates or wraps only as specified above.

Optional Feature:
- Macro: LED_FSM_AUTO_OFF_EN.
- Defined:
  - Each channel has a timeout counter. It counts while the channel is in ON or BLINK and clears on a press, in OFF, and on Force_Off.
  - When the counter reaches TIMEOUT-1, the channel goes to OFF on the next edge and Led falls on that edge.
  - A press on the same edge as the timeout wins: the state advances normally and the counter clears.
- Undefined: no timeout logic is built, TIMEOUT is ignored, and ON/BLINK hold indefinitely.

Test Plan:
- Reset release with IN=0 -> Led=0000 and Estado_Salida=0x00 held for 100 cycles.
- DEB_CYCLES=4: IN[0] rising before E0 and held 10 cycles -> Estado_Salida[1:0]=01 and Led[0]=1 exactly at edge E0+6. Glitch of 3 cycles -> no change.
- Three clean presses on channel 2 with BLINK_HALF=4 -> states 01, 10, 00. In BLINK, Led[2] toggles every 4 cycles in phase with the prescaler.
- Simultaneous presses on channels 0 and 3, with Force_Off pulsed on the edge where channel 1's press takes effect:
  - Channels 0 and 3 advance.
  - Channel 1 goes to 00.
  - All Led=0 after Force_Off.
- Reset dropped asynchronously mid-blink (between edges) -> Led and Estado_Salida go to 0 before the next Clk edge.
- With LED_FSM_AUTO_OFF_EN and TIMEOUT=8:
  - A channel in ON returns to 00 after 8 idle cycles.
  - A press coinciding with the timeout edge moves the channel to BLINK instead.
